// File: rtl/imgproc_pkg.sv
// Shared types and constants for the image-processing stream stages.
// Luma uses fixed-point BT.601-style weights that sum to 256.
package imgproc_pkg;

    localparam int PIX_DATA_W = 32;

    typedef logic [23:0] pixel_t;

    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

    localparam logic [PIX_DATA_W-1:0] FG_PIXEL = 32'h00FF_FFFF;
    localparam logic [PIX_DATA_W-1:0] BG_PIXEL = 32'h0000_0000;

    typedef struct packed {
        logic [PIX_DATA_W-1:0] data;
        logic                  user;
        logic                  last;
    } beat_t;

    // Weights sum to 256, so the 16-bit sum cannot overflow and [15:8] is Y.
    function automatic logic [7:0] luma(input pixel_t p);
        logic [15:0] sum;
        sum = 16'(p[23:16]) * 16'(LUMA_R)
            + 16'(p[15:8])  * 16'(LUMA_G)
            + 16'(p[7:0])   * 16'(LUMA_B);
        return sum[15:8];
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry stream output stage: an output register plus one overflow slot,
// with in_ready driven straight from a flop (low while in reset).
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    // Handshake: a beat moves on either side when valid && ready at a rising
    // edge; out_data/out_valid hold steady while out_valid && !out_ready.
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;
    logic         in_fire;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire      = in_valid && in_ready_q;

        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/pixel_threshold_stream.sv
// RGB -> luma -> threshold stream stage with regenerated end-of-line TLAST.
// Optional foreground pixel counter enabled by defining IMGPROC_FG_COUNT_EN.
module pixel_threshold_stream
    import imgproc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COL_W  = 12
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              cfg_enable,
    input  logic              cfg_invert,
    input  logic [7:0]        cfg_threshold,
    input  logic [COL_W-1:0]  cfg_width,
    input  logic              cfg_clear_err,
    output logic              line_err,
    output logic [31:0]       fg_count
);

    localparam int PAY_W = $bits(beat_t) + 1;

    logic             pipe_en;
    logic             in_fire;

    logic             have_sof_q, have_sof_d;
    logic             sh_en_q, sh_en_d;
    logic             sh_inv_q, sh_inv_d;
    logic [7:0]       sh_thr_q, sh_thr_d;
    logic [COL_W-1:0] sh_width_q, sh_width_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             line_err_q, line_err_d;

    logic             eff_en, eff_inv;
    logic [7:0]       eff_thr;
    logic [COL_W-1:0] eff_width, w_eff, col_start;
    logic             is_last, err_set;

    logic              s1_valid_q, s1_valid_d;
    logic [7:0]        s1_luma_q, s1_luma_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_user_q, s1_user_d;
    logic              s1_last_q, s1_last_d;
    logic              s1_en_q, s1_en_d;
    logic              s1_inv_q, s1_inv_d;
    logic [7:0]        s1_thr_q, s1_thr_d;

    logic              fg_raw, s2_fg;
    beat_t             s2_beat, out_beat;
    logic [PAY_W-1:0]  skid_out;
    logic              out_fg;

    // Both pipeline registers move only when the skid buffer has room.
    assign in_fire = s_axis_tvalid && pipe_en;

    always_comb begin
        // A SOF beat uses (and captures) the live config; otherwise the frame's shadow.
        if (s_axis_tuser || !have_sof_q) begin
            eff_en    = cfg_enable;
            eff_inv   = cfg_invert;
            eff_thr   = cfg_threshold;
            eff_width = cfg_width;
        end else begin
            eff_en    = sh_en_q;
            eff_inv   = sh_inv_q;
            eff_thr   = sh_thr_q;
            eff_width = sh_width_q;
        end

        w_eff     = (eff_width == '0) ? COL_W'(1) : eff_width;
        col_start = s_axis_tuser ? '0 : col_q;
        is_last   = (col_start == w_eff - COL_W'(1));
        err_set   = in_fire && ((s_axis_tlast != is_last) ||
                                (s_axis_tuser && (col_q != '0)));

        have_sof_d = have_sof_q;
        sh_en_d    = sh_en_q;
        sh_inv_d   = sh_inv_q;
        sh_thr_d   = sh_thr_q;
        sh_width_d = sh_width_q;
        col_d      = col_q;

        if (in_fire) begin
            col_d = is_last ? '0 : col_start + COL_W'(1);
            if (s_axis_tuser) begin
                have_sof_d = 1'b1;
                sh_en_d    = cfg_enable;
                sh_inv_d   = cfg_invert;
                sh_thr_d   = cfg_threshold;
                sh_width_d = cfg_width;
            end
        end

        if (err_set) begin
            line_err_d = 1'b1;
        end else if (cfg_clear_err) begin
            line_err_d = 1'b0;
        end else begin
            line_err_d = line_err_q;
        end

        s1_valid_d = s1_valid_q;
        s1_luma_d  = s1_luma_q;
        s1_data_d  = s1_data_q;
        s1_user_d  = s1_user_q;
        s1_last_d  = s1_last_q;
        s1_en_d    = s1_en_q;
        s1_inv_d   = s1_inv_q;
        s1_thr_d   = s1_thr_q;
        if (pipe_en) begin
            s1_valid_d = s_axis_tvalid;
            s1_luma_d  = luma(s_axis_tdata[23:0]);
            s1_data_d  = s_axis_tdata;
            s1_user_d  = s_axis_tuser;
            s1_last_d  = is_last;
            s1_en_d    = eff_en;
            s1_inv_d   = eff_inv;
            s1_thr_d   = eff_thr;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            have_sof_q <= 1'b0;
            sh_en_q    <= 1'b0;
            sh_inv_q   <= 1'b0;
            sh_thr_q   <= '0;
            sh_width_q <= '0;
            col_q      <= '0;
            line_err_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_luma_q  <= '0;
            s1_data_q  <= '0;
            s1_user_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_thr_q   <= '0;
        end else begin
            have_sof_q <= have_sof_d;
            sh_en_q    <= sh_en_d;
            sh_inv_q   <= sh_inv_d;
            sh_thr_q   <= sh_thr_d;
            sh_width_q <= sh_width_d;
            col_q      <= col_d;
            line_err_q <= line_err_d;
            s1_valid_q <= s1_valid_d;
            s1_luma_q  <= s1_luma_d;
            s1_data_q  <= s1_data_d;
            s1_user_q  <= s1_user_d;
            s1_last_q  <= s1_last_d;
            s1_en_q    <= s1_en_d;
            s1_inv_q   <= s1_inv_d;
            s1_thr_q   <= s1_thr_d;
        end
    end

    // Second stage: the compare result is registered by the skid buffer's output slot.
    always_comb begin
        fg_raw       = (s1_luma_q >= s1_thr_q) ^ s1_inv_q;
        s2_fg        = s1_en_q && fg_raw;
        s2_beat.data = s1_en_q ? (fg_raw ? FG_PIXEL : BG_PIXEL) : s1_data_q;
        s2_beat.user = s1_user_q;
        s2_beat.last = s1_last_q;
    end

    axis_skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (ACLK),
        .rst       (ARESET),
        .in_data   ({s2_fg, s2_beat}),
        .in_valid  (s1_valid_q),
        .in_ready  (pipe_en),
        .out_data  (skid_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign out_fg        = skid_out[PAY_W-1];
    assign out_beat      = skid_out[PAY_W-2:0];
    assign m_axis_tdata  = out_beat.data;
    assign m_axis_tuser  = out_beat.user;
    assign m_axis_tlast  = out_beat.last;
    assign s_axis_tready = pipe_en;
    assign line_err      = line_err_q;

`ifdef IMGPROC_FG_COUNT_EN
    logic        out_fire;
    logic [31:0] fg_cnt_q, fg_cnt_d;
    logic [31:0] fg_count_q, fg_count_d;

    assign out_fire = m_axis_tvalid && m_axis_tready;

    // The SOF beat closes the previous frame and is itself the new frame's first pixel.
    always_comb begin
        fg_cnt_d   = fg_cnt_q;
        fg_count_d = fg_count_q;
        if (out_fire) begin
            if (out_beat.user) begin
                fg_count_d = fg_cnt_q;
                fg_cnt_d   = {31'b0, out_fg};
            end else begin
                fg_cnt_d = fg_cnt_q + {31'b0, out_fg};
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            fg_cnt_q   <= '0;
            fg_count_q <= '0;
        end else begin
            fg_cnt_q   <= fg_cnt_d;
            fg_count_q <= fg_count_d;
        end
    end

    assign fg_count = fg_count_q;
`else
    logic unused_fg;
    assign unused_fg = out_fg;
    assign fg_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pixel_threshold_stream.sv
// Directed bench for pixel_threshold_stream: binarise, bypass, stalls, TLAST
// regeneration, shadow config, fg_count (IMGPROC_FG_COUNT_EN) and mid-line reset.
module tb_pixel_threshold_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tuser, m_tlast, m_tvalid;
    logic        m_tready = 1'b1;
    logic        cfg_enable = 1'b1, cfg_invert = 1'b0, cfg_clear_err = 1'b0;
    logic [7:0]  cfg_threshold = 8'h80;
    logic [11:0] cfg_width = 12'd4;
    logic        line_err;
    logic [31:0] fg_count;

    int checks = 0;
    int errors = 0;
    logic [33:0] obs_q[$];

    pixel_threshold_stream dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .cfg_enable    (cfg_enable),
        .cfg_invert    (cfg_invert),
        .cfg_threshold (cfg_threshold),
        .cfg_width     (cfg_width),
        .cfg_clear_err (cfg_clear_err),
        .line_err      (line_err),
        .fg_count      (fg_count)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1; a beat seen valid&&ready here transfers at the next posedge.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) obs_q.push_back({m_tdata, m_tuser, m_tlast});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
        int n;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_tready) begin
            errors++;
            $display("FAIL send_timeout data=%h tready=%b required 1", d, s_tready);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL out_timeout got %0d beats required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_tready, m_tvalid, m_tuser, m_tlast, line_err, m_tdata, fg_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs tready=%b valid=%b data=%h err=%b fg=%0d required all 0",
                     s_tready, m_tvalid, m_tdata, line_err, fg_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early tready=%b required 0", s_tready);
        end
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise tready=%b required 1", s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_binarise();
        logic [33:0] exp_b[4];
        logic [33:0] got;
        exp_b = '{{32'h00FFFFFF, 2'b10}, {32'h0, 2'b00}, {32'h00FFFFFF, 2'b00}, {32'h0, 2'b01}};
        cfg_enable = 1'b1; cfg_invert = 1'b0; cfg_threshold = 8'h80; cfg_width = 12'd4;
        obs_q.delete();
        send_beat(32'h00FFFFFF, 1'b1, 1'b0);
        send_beat(32'h00000000, 1'b0, 1'b0);
        send_beat(32'h00808080, 1'b0, 1'b0);
        send_beat(32'h007F7F7F, 1'b0, 1'b1);
        wait_outs(4);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== exp_b[i]) begin
                errors++;
                $display("FAIL binarise_beat%0d got %h required %h", i, got, exp_b[i]);
            end
        end
        checks++;
        if (obs_q.size() != 4 || line_err !== 1'b0) begin
            errors++;
            $display("FAIL binarise_count beats=%0d err=%b required 4/0", obs_q.size(), line_err);
        end
    endtask

    task automatic test_bypass();
        logic [33:0] got;
        cfg_enable = 1'b0; cfg_width = 12'd1;
        obs_q.delete();
        s_tdata = 32'h00123456; s_tuser = 1'b1; s_tlast = 1'b1; s_tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL bypass_accept tready=%b required 1", s_tready);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_latency_early valid=%b required 0", m_tvalid);
        end
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== {1'b1, 32'h00123456, 2'b11}) begin
            errors++;
            $display("FAIL bypass_latency valid=%b data=%h u=%b l=%b required 1 00123456 1 1",
                     m_tvalid, m_tdata, m_tuser, m_tlast);
        end
        @(posedge clk); #1;
        obs_q.delete();
        send_beat(32'hAB00FF01, 1'b1, 1'b1);
        wait_outs(1);
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        checks++;
        if (got !== {32'hAB00FF01, 2'b11}) begin
            errors++;
            $display("FAIL bypass_upper_byte got %h required %h", got, {32'hAB00FF01, 2'b11});
        end
        idle(2);
    endtask

    task automatic test_invert();
        logic [33:0] got;
        cfg_enable = 1'b1; cfg_invert = 1'b1; cfg_width = 12'd1; cfg_threshold = 8'h80;
        obs_q.delete();
        send_beat(32'h00FFFFFF, 1'b1, 1'b1);
        send_beat(32'h00000000, 1'b1, 1'b1);
        wait_outs(2);
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        checks++;
        if (got !== {32'h0, 2'b11}) begin
            errors++;
            $display("FAIL invert_white got %h required %h", got, {32'h0, 2'b11});
        end
        got = (obs_q.size() > 1) ? obs_q[1] : 'x;
        checks++;
        if (got !== {32'h00FFFFFF, 2'b11}) begin
            errors++;
            $display("FAIL invert_black got %h required %h", got, {32'h00FFFFFF, 2'b11});
        end
        cfg_invert = 1'b0;
        idle(2);
    endtask

    task automatic test_width_zero();
        logic [33:0] exp_b[3];
        logic [33:0] got;
        exp_b = '{{32'h00FFFFFF, 2'b11}, {32'h00FFFFFF, 2'b01}, {32'h0, 2'b01}};
        cfg_width = 12'd0;
        obs_q.delete();
        send_beat(32'h00FFFFFF, 1'b1, 1'b1);
        send_beat(32'h00808080, 1'b0, 1'b1);
        send_beat(32'h00000000, 1'b0, 1'b1);
        wait_outs(3);
        for (int i = 0; i < 3; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== exp_b[i]) begin
                errors++;
                $display("FAIL width0_beat%0d got %h required %h", i, got, exp_b[i]);
            end
        end
        checks++;
        if (line_err !== 1'b0) begin
            errors++;
            $display("FAIL width0_err line_err=%b required 0", line_err);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [33:0] exp_b[4];
        logic [33:0] got;
        logic [31:0] snap;
        logic        snap_v, stable;
        exp_b = '{{32'h00FFFFFF, 2'b10}, {32'h0, 2'b00}, {32'h00FFFFFF, 2'b00}, {32'h0, 2'b01}};
        cfg_width = 12'd4; cfg_enable = 1'b1;
        obs_q.delete();
        m_tready = 1'b0;
        fork
            begin
                send_beat(32'h00FFFFFF, 1'b1, 1'b0);
                send_beat(32'h00000000, 1'b0, 1'b0);
                send_beat(32'h00FFFFFF, 1'b0, 1'b0);
                send_beat(32'h00000000, 1'b0, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                snap = m_tdata; snap_v = m_tvalid; stable = 1'b1;
                repeat (7) begin
                    @(negedge clk);
                    if (m_tdata !== snap || m_tvalid !== snap_v || m_tuser !== 1'b1) stable = 1'b0;
                end
                checks++;
                if (!stable || snap_v !== 1'b1 || snap !== 32'h00FFFFFF) begin
                    errors++;
                    $display("FAIL stall_stable stable=%b valid=%b data=%h required 1 1 00ffffff",
                             stable, snap_v, snap);
                end
                checks++;
                if (s_tready !== 1'b0 || obs_q.size() != 0) begin
                    errors++;
                    $display("FAIL stall_ready tready=%b beats=%0d required 0 0", s_tready, obs_q.size());
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        wait_outs(4);
        idle(4);
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count got %0d beats required 4", obs_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            checks++;
            if (got !== exp_b[i]) begin
                errors++;
                $display("FAIL stall_beat%0d got %h required %h", i, got, exp_b[i]);
            end
        end
    endtask

    task automatic test_line_err();
        logic [3:0] lasts;
        logic [4:0] lasts5;
        cfg_width = 12'd4;
        obs_q.delete();
        send_beat(32'h00FFFFFF, 1'b1, 1'b0);
        send_beat(32'h00FFFFFF, 1'b0, 1'b0);
        send_beat(32'h00FFFFFF, 1'b0, 1'b1);
        send_beat(32'h00FFFFFF, 1'b0, 1'b0);
        wait_outs(4);
        idle(2);
        lasts = '0;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) lasts[i] = obs_q[i][0];
        checks++;
        if (line_err !== 1'b1 || lasts !== 4'b1000) begin
            errors++;
            $display("FAIL lineerr_set err=%b lasts=%b required 1 1000", line_err, lasts);
        end
        cfg_clear_err = 1'b1;
        @(posedge clk); #1;
        cfg_clear_err = 1'b0;
        @(negedge clk);
        checks++;
        if (line_err !== 1'b0) begin
            errors++;
            $display("FAIL lineerr_clear err=%b required 0", line_err);
        end
        @(posedge clk); #1;
        // SOF arriving mid-line restarts the column count.
        obs_q.delete();
        send_beat(32'h0, 1'b1, 1'b0);
        send_beat(32'h0, 1'b1, 1'b0);
        send_beat(32'h0, 1'b0, 1'b0);
        send_beat(32'h0, 1'b0, 1'b0);
        send_beat(32'h0, 1'b0, 1'b1);
        wait_outs(5);
        idle(2);
        lasts5 = '0;
        for (int i = 0; i < 5 && i < obs_q.size(); i++) lasts5[i] = obs_q[i][0];
        checks++;
        if (line_err !== 1'b1 || lasts5 !== 5'b10000) begin
            errors++;
            $display("FAIL sof_midline err=%b lasts=%b required 1 10000", line_err, lasts5);
        end
        cfg_clear_err = 1'b1;
        @(posedge clk); #1;
        cfg_clear_err = 1'b0;
        // Error on the same edge as a clear pulse: the set must win.
        s_tdata = 32'h0; s_tuser = 1'b1; s_tlast = 1'b1; s_tvalid = 1'b1; cfg_clear_err = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; cfg_clear_err = 1'b0;
        @(negedge clk);
        checks++;
        if (line_err !== 1'b1) begin
            errors++;
            $display("FAIL set_over_clear err=%b required 1", line_err);
        end
        @(posedge clk); #1;
        send_beat(32'h0, 1'b0, 1'b0);
        send_beat(32'h0, 1'b0, 1'b0);
        send_beat(32'h0, 1'b0, 1'b1);
        cfg_clear_err = 1'b1;
        @(posedge clk); #1;
        cfg_clear_err = 1'b0;
        idle(4);
        checks++;
        if (line_err !== 1'b0) begin
            errors++;
            $display("FAIL lineerr_final err=%b required 0", line_err);
        end
    endtask

    task automatic test_shadow_cfg();
        logic [31:0] got;
        logic [31:0] exp_d;
        cfg_width = 12'd4; cfg_threshold = 8'h80;
        obs_q.delete();
        send_beat(32'h00303030, 1'b1, 1'b0);
        send_beat(32'h00303030, 1'b0, 1'b0);
        cfg_threshold = 8'h10;
        send_beat(32'h00303030, 1'b0, 1'b0);
        send_beat(32'h00303030, 1'b0, 1'b1);
        send_beat(32'h00303030, 1'b1, 1'b0);
        send_beat(32'h00303030, 1'b0, 1'b0);
        send_beat(32'h00303030, 1'b0, 1'b0);
        send_beat(32'h00303030, 1'b0, 1'b1);
        wait_outs(8);
        for (int i = 0; i < 8; i++) begin
            got = (i < obs_q.size()) ? obs_q[i][33:2] : 'x;
            exp_d = (i < 4) ? 32'h0 : 32'h00FFFFFF;
            checks++;
            if (got !== exp_d) begin
                errors++;
                $display("FAIL shadow_thr_beat%0d got %h required %h", i, got, exp_d);
            end
        end
        cfg_threshold = 8'h80;
        idle(2);
    endtask

    task automatic test_fg_count();
        logic [31:0] exp_fg;
`ifdef IMGPROC_FG_COUNT_EN
        exp_fg = 32'd5;
`else
        exp_fg = 32'd0;
`endif
        cfg_width = 12'd4; cfg_enable = 1'b1; cfg_threshold = 8'h80; cfg_invert = 1'b0;
        obs_q.delete();
        send_beat(32'h00FFFFFF, 1'b1, 1'b0);
        send_beat(32'h00000000, 1'b0, 1'b0);
        send_beat(32'h00FFFFFF, 1'b0, 1'b0);
        send_beat(32'h00FFFFFF, 1'b0, 1'b1);
        send_beat(32'h00FFFFFF, 1'b0, 1'b0);
        send_beat(32'h00000000, 1'b0, 1'b0);
        send_beat(32'h00FFFFFF, 1'b0, 1'b0);
        send_beat(32'h00000000, 1'b0, 1'b1);
        send_beat(32'h00FFFFFF, 1'b1, 1'b0);
        wait_outs(9);
        idle(3);
        checks++;
        if (fg_count !== exp_fg) begin
            errors++;
            $display("FAIL fg_count got %0d required %0d", fg_count, exp_fg);
        end
        // Reset while a beat sits in the pipeline, mid-line.
        s_tdata = 32'h00FFFFFF; s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_tready, m_tvalid, m_tuser, m_tlast, line_err, m_tdata, fg_count} !== '0) begin
            errors++;
            $display("FAIL midline_reset tready=%b valid=%b data=%h err=%b fg=%0d required all 0",
                     s_tready, m_tvalid, m_tdata, line_err, fg_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        obs_q.delete();
        idle(6);
        checks++;
        if (obs_q.size() != 0 || m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset beats=%0d valid=%b tready=%b required 0 0 1",
                     obs_q.size(), m_tvalid, s_tready);
        end
    endtask

    initial begin
        test_reset();
        test_binarise();
        test_bypass();
        test_invert();
        test_width_zero();
        test_backpressure();
        test_line_err();
        test_shadow_cfg();
        test_fg_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
